// File: rtl/imem_writer_if.sv
// imem_writer_if -- bundle of the instruction-writer handshake and the
// instruction-memory byte write port.
//
// Signals (directions as seen by the writer, modport slave):
//   in_valid_i / in_ready_o          instruction handshake
//   icode_i, ifun_i, rA_i, rB_i      Y86-64 instruction fields (4 bits each)
//   valC_i                           64-bit constant word
//   set_addr_i / addr_i              load the write pointer (10 bits)
//   mem_we_o / mem_addr_o / mem_data_o  registered byte write port
//   wr_ptr_o                         next free byte address
//   done_o                           pulse with the last byte of an instruction
//   err_o / err_code_o               sticky error, 01 bad icode, 10 overflow
//   instr_cnt_o                      completed instruction count (wraps)
//
// Handshake: an instruction transfers on a rising clock edge where
// in_valid_i && in_ready_o. The source holds the fields stable while
// in_valid_i is high and waiting; in_ready_o never depends on in_valid_i.
interface imem_writer_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  icode_i;
    logic [3:0]  ifun_i;
    logic [3:0]  rA_i;
    logic [3:0]  rB_i;
    logic [63:0] valC_i;
    logic        set_addr_i;
    logic [9:0]  addr_i;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [7:0]  mem_data_o;
    logic [9:0]  wr_ptr_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [15:0] instr_cnt_o;

    // Writer side.
    modport slave (
        input  in_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
               set_addr_i, addr_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, wr_ptr_o,
               done_o, err_o, err_code_o, instr_cnt_o
    );

    // Instruction source / memory side.
    modport master (
        output in_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
               set_addr_i, addr_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, wr_ptr_o,
               done_o, err_o, err_code_o, instr_cnt_o
    );
endinterface

// File: rtl/imem_writer.sv
// imem_writer -- serialises Y86-64 instructions into an instruction memory,
// one byte per clock, at consecutive addresses starting at the write pointer.
//
// Ports:
//   clk_i        system clock (rising edge)
//   rst_i        synchronous active-high reset
//   bus          imem_writer_if.slave (handshake, fields, byte write port,
//                pointer, done pulse, sticky error, instruction counter)
//   dbg_state_o  current FSM state: 0 IDLE, 1 WRITE, 2 ERROR
//
// Encoding: byte0 = {icode,ifun}; byte1 = {rA,rB} when register ids are
// present; then valC, 8 bytes little-endian. Instruction length is 1, 2, 9
// or 10 bytes.
//
// Timing: the first byte is registered on the acceptance edge, so mem_we_o
// is high the cycle after acceptance. The FSM stays in WRITE for exactly N
// cycles (one per byte shown on the port) and returns to IDLE after the
// last one, so in_ready_o is low for N cycles per instruction.
module imem_writer (
    input  logic            clk_i,
    input  logic            rst_i,
    imem_writer_if.slave    bus,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [71:0] buf_q, buf_d;     // bytes still to emit, lowest byte next
    logic [3:0]  rem_q, rem_d;     // bytes left after the one on the port
    logic        we_q, we_d;
    logic [9:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_ready;
    logic        xfer;
    logic        need_regs;
    logic        need_valc;
    logic        bad_icode;
    logic [3:0]  len;
    logic [9:0]  base;
    logic [10:0] last_addr;
    logic [79:0] enc;

    assign in_ready = (state_q == ST_IDLE) && !rst_i;
    assign xfer     = bus.in_valid_i && in_ready;

    // Decode of the offered instruction. A simultaneous set_addr_i moves
    // the base address before the instruction is placed.
    always_comb begin
        need_regs = 1'b0;
        need_valc = 1'b0;
        enc       = '0;
        case (bus.icode_i)
            4'h2, 4'h6, 4'hA, 4'hB: need_regs = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regs = 1'b1;
                need_valc = 1'b1;
            end
            4'h7, 4'h8:             need_valc = 1'b1;
            default: begin
                need_regs = 1'b0;
                need_valc = 1'b0;
            end
        endcase
        bad_icode = (bus.icode_i >= 4'hC);
        len       = 4'd1 + {3'b000, need_regs} + (need_valc ? 4'd8 : 4'd0);
        base      = bus.set_addr_i ? bus.addr_i : ptr_q;
        // 11-bit sum so the overflow bit is visible.
        last_addr = {1'b0, base} + {7'b0000000, len} - 11'd1;
        enc[7:0]  = {bus.icode_i, bus.ifun_i};
        if (need_regs) begin
            enc[15:8] = {bus.rA_i, bus.rB_i};
            if (need_valc) enc[79:16] = bus.valC_i;
        end else if (need_valc) begin
            enc[71:8] = bus.valC_i;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    ptr_d = base;
                    if (bad_icode) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = ST_ERROR;
                    end else if (last_addr[10]) begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = ST_ERROR;
                    end else begin
                        // Emit byte0 now; the rest drains from buf_q.
                        we_d    = 1'b1;
                        addr_d  = base;
                        data_d  = enc[7:0];
                        buf_d   = enc[79:8];
                        rem_d   = len - 4'd1;
                        ptr_d   = base + 10'd1;
                        state_d = ST_WRITE;
                        if (len == 4'd1) begin
                            done_d = 1'b1;
                            cnt_d  = cnt_q + 16'd1;
                        end
                    end
                end else if (bus.set_addr_i) begin
                    ptr_d = bus.addr_i;
                end
            end
            ST_WRITE: begin
                if (rem_q == 4'd0) begin
                    // Last byte was on the port this cycle.
                    state_d = ST_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = buf_q[7:0];
                    buf_d  = {8'h00, buf_q[71:8]};
                    rem_d  = rem_q - 4'd1;
                    ptr_d  = ptr_q + 10'd1;
                    if (rem_q == 4'd1) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = data_q;
    assign bus.wr_ptr_o    = ptr_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = code_q;
    assign bus.instr_cnt_o = cnt_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_imem_writer.sv
// Bench for imem_writer: directed scenarios plus randomized instructions,
// checked cycle by cycle against a byte-level reference model.
module tb_imem_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    imem_writer_if bus();

    imem_writer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];          // {addr, data} of bytes still expected
    logic [9:0]  m_ptr  = '0;
    logic [15:0] m_cnt  = '0;
    logic        m_err  = 1'b0;
    logic [1:0]  m_code = 2'b00;
    logic        noise_en = 1'b0;
    logic [7:0]  dut_mem [0:1023];

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-cycle monitor: every cycle's outputs are compared with the model.
    always @(negedge clk) begin
        logic        exp_ready;
        logic        last;
        logic [17:0] e;
        exp_ready = !rst && !m_err && (exp_q.size() == 0);
        check_eq("in_ready", bus.in_ready_o, exp_ready);
        if (exp_q.size() != 0) begin
            check_eq("mem_we", bus.mem_we_o, 1'b1);
            if (bus.mem_we_o === 1'b1) begin
                e = exp_q.pop_front();
                check_eq("mem_addr", bus.mem_addr_o, e[17:8]);
                check_eq("mem_data", bus.mem_data_o, e[7:0]);
                dut_mem[bus.mem_addr_o] = bus.mem_data_o;
                last  = (exp_q.size() == 0);
                m_ptr = e[17:8] + 10'd1;
                if (last) m_cnt = m_cnt + 16'd1;
                check_eq("done", bus.done_o, last);
            end
        end else begin
            check_eq("mem_we_idle", bus.mem_we_o, 1'b0);
            check_eq("done_idle", bus.done_o, 1'b0);
        end
        check_eq("wr_ptr", bus.wr_ptr_o, m_ptr);
        check_eq("instr_cnt", bus.instr_cnt_o, m_cnt);
        check_eq("err", bus.err_o, m_err);
        check_eq("err_code", bus.err_code_o, m_code);
    end

    // ---------------- driver tasks (enter/leave at posedge+1) ----------------
    task automatic do_reset();
        bus.in_valid_i = 1'b0;
        bus.set_addr_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        m_ptr  = '0;
        m_cnt  = '0;
        m_err  = 1'b0;
        m_code = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready_o) check_eq("idle_timeout", 1'b0, 1'b1);
    endtask

    task automatic set_ptr(input logic [9:0] a);
        wait_idle();
        bus.set_addr_i = 1'b1;
        bus.addr_i     = a;
        @(posedge clk); #1;
        bus.set_addr_i = 1'b0;
        m_ptr = a;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic set,
                        input logic [9:0] a);
        int         n = 0;
        int         len;
        logic       regs;
        logic       vcn;
        logic [9:0] base;
        logic [9:0] ad;
        bus.icode_i    = ic;
        bus.ifun_i     = fn;
        bus.rA_i       = ra;
        bus.rB_i       = rb;
        bus.valC_i     = vc;
        bus.set_addr_i = set;
        bus.addr_i     = a;
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.in_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            check_eq("accept_timeout", 1'b0, 1'b1);
            bus.in_valid_i = 1'b0;
            bus.set_addr_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.set_addr_i = 1'b0;
        // Reference: instruction layout from the Y86-64 field rules.
        regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        vcn  = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        len  = 1 + int'(regs) + 8 * int'(vcn);
        base = set ? a : m_ptr;
        if (set) m_ptr = a;
        if (ic >= 4'hC) begin
            m_err  = 1'b1;
            m_code = 2'b01;
        end else if (int'(base) + len - 1 > 1023) begin
            m_err  = 1'b1;
            m_code = 2'b10;
        end else begin
            exp_q.push_back({base, ic, fn});
            ad = base + 10'd1;
            if (regs) begin
                exp_q.push_back({ad, ra, rb});
                ad = ad + 10'd1;
            end
            if (vcn) begin
                for (int j = 0; j < 8; j++) begin
                    exp_q.push_back({ad, vc[8*j +: 8]});
                    ad = ad + 10'd1;
                end
            end
        end
        // Set-address requests while busy or in error must be ignored.
        if (noise_en && $urandom_range(0, 3) == 0) begin
            bus.set_addr_i = 1'b1;
            bus.addr_i     = 10'($urandom_range(0, 1023));
            @(posedge clk); #1;
            bus.set_addr_i = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] r_ic;
        int         r;
        bus.in_valid_i = 1'b0;
        bus.set_addr_i = 1'b0;
        bus.addr_i     = '0;
        bus.icode_i    = '0;
        bus.ifun_i     = '0;
        bus.rA_i       = '0;
        bus.rB_i       = '0;
        bus.valC_i     = '0;
        for (int i = 0; i < 1024; i++) dut_mem[i] = 8'hxx;

        do_reset();
        check_eq("rst_ptr", bus.wr_ptr_o, 10'd0);
        check_eq("rst_cnt", bus.instr_cnt_o, 16'd0);

        // irmovq 0x8,%r8 at 0
        send(4'h3, 4'h0, 4'hF, 4'h8, 64'h8, 1'b0, 10'd0);
        wait_idle();
        check_eq("irmovq_b0", dut_mem[0], 8'h30);
        check_eq("irmovq_b1", dut_mem[1], 8'hF8);
        check_eq("irmovq_b2", dut_mem[2], 8'h08);
        check_eq("irmovq_b9", dut_mem[9], 8'h00);
        check_eq("irmovq_ptr", bus.wr_ptr_o, 10'd10);
        check_eq("irmovq_cnt", bus.instr_cnt_o, 16'd1);

        // halt, nop back to back
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 10'd0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 10'd0);
        wait_idle();
        check_eq("halt_byte", dut_mem[10], 8'h00);
        check_eq("nop_byte", dut_mem[11], 8'h10);
        check_eq("halt_nop_ptr", bus.wr_ptr_o, 10'd12);

        // addq %rax,%rbx ; call 0x100
        send(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 1'b0, 10'd0);
        send(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 1'b0, 10'd0);
        wait_idle();
        check_eq("addq_b0", dut_mem[12], 8'h60);
        check_eq("addq_b1", dut_mem[13], 8'h03);
        check_eq("call_b0", dut_mem[14], 8'h80);
        check_eq("call_b1", dut_mem[15], 8'h00);
        check_eq("call_b2", dut_mem[16], 8'h01);
        check_eq("addq_call_ptr", bus.wr_ptr_o, 10'd23);

        // set_addr together with a transfer: instruction lands at addr_i
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1, 10'd500);
        wait_idle();
        check_eq("set_xfer_byte", dut_mem[500], 8'h10);
        check_eq("set_xfer_ptr", bus.wr_ptr_o, 10'd501);

        // 10-byte instruction ending exactly at 1023
        set_ptr(10'd1014);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h1122334455667788, 1'b0, 10'd0);
        wait_idle();
        check_eq("top_byte", dut_mem[1023], 8'h11);
        check_eq("top_ptr_wrap", bus.wr_ptr_o, 10'd0);

        // invalid icode
        send(4'hD, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 10'd0);
        @(negedge clk);
        check_eq("bad_icode_code", bus.err_code_o, 2'b01);
        check_eq("bad_icode_ptr", bus.wr_ptr_o, 10'd0);
        check_eq("bad_icode_state", dbg_state, 2'd2);
        @(posedge clk); #1;
        do_reset();

        // overflow
        set_ptr(10'd1020);
        send(4'h3, 4'h0, 4'hF, 4'h8, 64'h8, 1'b0, 10'd0);
        bus.set_addr_i = 1'b1;   // ignored in ERROR
        bus.addr_i     = 10'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("ovf_ready", bus.in_ready_o, 1'b0);
            check_eq("ovf_code", bus.err_code_o, 2'b10);
        end
        @(posedge clk); #1;
        bus.set_addr_i = 1'b0;
        do_reset();

        // reset on the 4th byte of irmovq
        send(4'h3, 4'h0, 4'hF, 4'h8, 64'h8, 1'b0, 10'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        do_reset();
        check_eq("abort_we", bus.mem_we_o, 1'b0);
        check_eq("abort_ptr", bus.wr_ptr_o, 10'd0);
        check_eq("abort_cnt", bus.instr_cnt_o, 16'd0);
        @(negedge clk);
        check_eq("abort_ready", bus.in_ready_o, 1'b1);
        @(posedge clk); #1;

        // randomized phase
        noise_en = 1'b1;
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 11);
            if (m_err) begin
                do_reset();
            end else if (r == 0) begin
                set_ptr(($urandom_range(0, 1) == 0) ? 10'($urandom_range(990, 1023))
                                                    : 10'($urandom_range(0, 1023)));
            end else if (r == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end else begin
                r_ic = (r == 2) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
                send(r_ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), {$urandom, $urandom},
                     ($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)));
            end
        end
        if (!m_err) wait_idle();
        repeat (3) @(posedge clk);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_writer.md
IMEM_WRITER -- requirements
Module: imem_writer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i (rising edge) and rst_i.
REQ-002 clk_i  in  1  system clock.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 in_valid_i  in  1  instruction fields valid.
REQ-005 in_ready_o  out  1  writer can accept an instruction.
REQ-006 icode_i / ifun_i / rA_i / rB_i  in  4 each  Y86-64 instruction fields.
REQ-007 valC_i  in  64  constant word.
REQ-008 set_addr_i  in  1  load write pointer from addr_i.
REQ-009 addr_i  in  10  new write pointer value.
REQ-010 mem_we_o / mem_addr_o / mem_data_o  out  1 / 10 / 8  instruction-memory byte write port, registered.
REQ-011 wr_ptr_o  out  10  next free byte address.
REQ-012 done_o  out  1  one-cycle pulse with the last byte of an instruction.
REQ-013 err_o / err_code_o  out  1 / 2  sticky error; 01 invalid icode, 10 address overflow.
REQ-014 instr_cnt_o  out  16  instructions fully written, wraps at 0xFFFF.

Function
REQ-015 States: IDLE, WRITE, ERROR.
REQ-016 in_ready_o SHALL be 1 only in IDLE with rst_i low; transfer occurs when in_valid_i && in_ready_o.
REQ-017 Encoding: byte0 = {icode,ifun}; byte1 = {rA,rB} (rA high nibble) when regids needed; then valC, 8 bytes little-endian.
REQ-018 Regids needed for icode 2,3,4,5,6,A,B; valC needed for 3,4,5,7,8; length = 1 + regids + 8*valC (1, 2, 9 or 10).
REQ-019 Accepted icode >= 0xC: no byte written, err_code_o=01, err_o=1, go to ERROR.
REQ-020 Overflow: if wr_ptr + length - 1 > 1023, no byte written, err_code_o=10, err_o=1, go to ERROR.
REQ-021 Otherwise latch fields and go to WRITE; mem_we_o asserts the cycle after acceptance, one byte per cycle at consecutive addresses starting at wr_ptr.
REQ-022 wr_ptr_o SHALL increment by 1 with each written byte.
REQ-023 done_o and the instr_cnt_o increment SHALL coincide with the last byte; return to IDLE so in_ready_o is 1 the next cycle.
REQ-024 Transfer of an instruction of length N occupies N cycles; the next acceptance can occur no earlier than the cycle after the last byte.
REQ-025 set_addr_i SHALL be honoured only in IDLE; if simultaneous with a transfer, the new address applies first and the instruction is written from addr_i.
REQ-026 set_addr_i SHALL be ignored in WRITE and ERROR.
REQ-027 ERROR SHALL be left only by rst_i; in_ready_o=0 and mem_we_o=0 while in ERROR.
REQ-028 mem_data_o/mem_addr_o are don't-care when mem_we_o=0.

Reset
REQ-029 rst_i high SHALL force IDLE, wr_ptr_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, done_o=0, err_o=0, err_code_o=00, instr_cnt_o=0, in_ready_o=0.
REQ-030 Reset during WRITE SHALL abort the instruction; no write occurs in the cycle after reset is sampled, and instr_cnt_o is not incremented.

Verification
REQ-031 irmovq 0x8,%r8 (3,0,F,8,valC=8) at ptr 0 -> bytes 30 F8 08 00 00 00 00 00 00 00 at 0..9 over 10 cycles; done_o on the 10th; wr_ptr_o=10; instr_cnt_o=1.
REQ-032 halt (0,0) then nop (1,0) back to back from ptr 10 -> addr 10=00, addr 11=10; one byte each; in_ready_o low for exactly one cycle per instruction; wr_ptr_o=12.
REQ-033 addq %rax,%rbx (6,0,0,3), then call 0x100 (8,0,F,F) -> bytes 60 03, then 80 00 01 00 00 00 00 00 00; wr_ptr_o advances by 11.
REQ-034 set_addr_i with addr_i=1020, then irmovq -> no mem_we_o; err_code_o=10; in_ready_o stays 0 until rst_i.
REQ-035 icode 0xD accepted -> no mem_we_o; err_code_o=01; wr_ptr_o unchanged.
REQ-036 rst_i asserted on the 4th byte of irmovq -> mem_we_o=0 from the next cycle; wr_ptr_o=0; instr_cnt_o=0; in_ready_o=1 the cycle after rst_i drops.
